// File: rtl/music_player_if.sv
// Signal bundle between the music sequencer, its control source and the note ROM.
// The slave modport is the sequencer's view; master is the driving environment.
interface music_player_if #(
    parameter int unsigned NOTE_W = 33,
    parameter int unsigned ADDR_W = 7
);
    logic              start;
    logic              stop;
    logic              pause;
    logic              loop_en;
    logic [NOTE_W-1:0] note_in;
    logic [ADDR_W-1:0] addr;
    logic              beep;
    logic              playing;
    logic              done;

    modport master (
        output start, stop, pause, loop_en, note_in,
        input  addr, beep, playing, done
    );

    modport slave (
        input  start, stop, pause, loop_en, note_in,
        output addr, beep, playing, done
    );
endinterface

// File: rtl/music_player.sv
// Beat-rate ROM sequencer with square-wave tone generator for background music.
// Each note slot is FETCH, LATCH, then BEAT_CYCLES of PLAY.
module music_player #(
    parameter int unsigned NOTE_W      = 33,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned LAST_ADDR   = 127,
    parameter int unsigned BEAT_CYCLES = 6250000,
    parameter int unsigned REST_CODE   = 2500
) (
    input logic             clk,
    input logic             rst_n,
    music_player_if.slave   bus
);
    localparam int unsigned BEAT_W = $clog2(BEAT_CYCLES + 1);
    localparam int unsigned TONE_W = NOTE_W - 1;

    typedef enum logic [2:0] {StIdle, StFetch, StLatch, StPlay, StDone} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                beep_q, beep_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [TONE_W-1:0]   tone_q, tone_d;

    logic [TONE_W-1:0]   half;
    logic                silent;
    logic                beat_end;
    logic                at_last;

    assign half     = note_q[NOTE_W-1:1];
    assign silent   = (note_q == NOTE_W'(REST_CODE)) || (note_q < NOTE_W'(2));
    assign beat_end = (beat_q == BEAT_W'(BEAT_CYCLES - 1));
    assign at_last  = (addr_q == ADDR_W'(LAST_ADDR));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        beep_d  = 1'b0;
        note_d  = note_q;
        beat_d  = beat_q;
        tone_d  = tone_q;
        if (bus.stop) begin
            state_d = StIdle;
            addr_d  = '0;
            beat_d  = '0;
            tone_d  = '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (bus.start) begin
                        state_d = StFetch;
                        addr_d  = '0;
                    end
                end
                StFetch: state_d = StLatch;
                StLatch: begin
                    note_d  = bus.note_in;
                    beat_d  = '0;
                    tone_d  = '0;
                    state_d = StPlay;
                end
                StPlay: begin
                    // Paused: counters hold and beep falls back to its default of 0.
                    if (!bus.pause) begin
                        beat_d = beat_q + BEAT_W'(1);
                        if (!silent) begin
                            beep_d = beep_q;
                            if (tone_q == half - TONE_W'(1)) begin
                                beep_d = ~beep_q;
                                tone_d = '0;
                            end else begin
                                tone_d = tone_q + TONE_W'(1);
                            end
                        end
                        if (beat_end) begin
                            beep_d = 1'b0;
                            beat_d = '0;
                            if (!at_last) begin
                                addr_d  = addr_q + ADDR_W'(1);
                                state_d = StFetch;
                            end else if (bus.loop_en) begin
                                addr_d  = '0;
                                state_d = StFetch;
                            end else begin
                                state_d = StDone;
                            end
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            beep_q  <= 1'b0;
            note_q  <= '0;
            beat_q  <= '0;
            tone_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beep_q  <= beep_d;
            note_q  <= note_d;
            beat_q  <= beat_d;
            tone_q  <= tone_d;
        end
    end

    assign bus.addr    = addr_q;
    assign bus.beep    = beep_q;
    assign bus.playing = (state_q == StFetch) || (state_q == StLatch) || (state_q == StPlay);
    assign bus.done    = (state_q == StDone);
endmodule

// File: tb/tb_music_player.sv
// Bench for music_player: short beat, 4-note tune, registered stub ROM, scoreboard checks.
module tb_music_player;
    localparam int NOTE_W   = 33;
    localparam int ADDR_W   = 7;
    localparam int LAST     = 3;
    localparam int BEAT     = 8;
    localparam int REST     = 2500;
    localparam int SLOT     = BEAT + 2;
    localparam int TUNE_LEN = (LAST + 1) * SLOT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    music_player_if #(.NOTE_W(NOTE_W), .ADDR_W(ADDR_W)) bus ();

    music_player #(
        .NOTE_W(NOTE_W), .ADDR_W(ADDR_W), .LAST_ADDR(LAST),
        .BEAT_CYCLES(BEAT), .REST_CODE(REST)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // Stub ROM with one-cycle latency.
    int cur_note = 10;
    int rest_addr = -1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.note_in <= '0;
        else bus.note_in <= (int'(bus.addr) == rest_addr) ? NOTE_W'(REST) : NOTE_W'(cur_note);
    end

    typedef struct {
        int                cyc;
        string             name;
        logic [ADDR_W-1:0] addr;
        logic              beep;
        logic              playing;
        logic              done;
    } obs_t;

    typedef struct {
        string name;
        int    note;
        int    rest;
        bit    loop_early;
        bit    loop_late;
        int    poke;
        int    len;
    } scen_t;

    obs_t  sb[$];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    scen_t tbl[7];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic obs_t mk(input int a, input bit b, input bit p, input bit d);
        obs_t o;
        o.cyc = 0;
        o.name = "";
        o.addr = ADDR_W'(a);
        o.beep = b;
        o.playing = p;
        o.done = d;
        return o;
    endfunction

    // Expected outputs k cycles after the start edge, derived from slot arithmetic.
    function automatic obs_t model(input int k, input int note, input int rest, input bit lp);
        obs_t o;
        int a, pos, n, half;
        bit aud;
        if (!lp && k >= TUNE_LEN) return mk(LAST, 1'b0, 1'b0, 1'b1);
        a = (k / SLOT) % (LAST + 1);
        pos = k % SLOT;
        n = (a == rest) ? REST : note;
        half = n / 2;
        aud = (n != REST) && (n >= 2);
        o = mk(a, 1'b0, 1'b1, 1'b0);
        if (pos >= 2 && aud) o.beep = (((pos - 2) / half) % 2) == 1;
        return o;
    endfunction

    task automatic compare(input obs_t e);
        checks++;
        if (bus.addr !== e.addr || bus.beep !== e.beep || bus.playing !== e.playing ||
            bus.done !== e.done) begin
            errors++;
            $display("FAIL %s @cyc %0d: got addr=%0d beep=%0b playing=%0b done=%0b, expected addr=%0d beep=%0b playing=%0b done=%0b",
                     e.name, cyc, bus.addr, bus.beep, bus.playing, bus.done,
                     e.addr, e.beep, e.playing, e.done);
        end
    endtask

    always @(negedge clk) begin : monitor
        obs_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            compare(e);
        end
    end

    // Push the expectation for the result of the coming edge, then advance one cycle.
    task automatic step(input string name, input obs_t e);
        e.cyc = cyc + 1;
        e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic check_now(input string name, input obs_t e);
        e.name = name;
        compare(e);
    endtask

    task automatic begin_tune(input int note, input int rest, input bit lp);
        cur_note = note;
        rest_addr = rest;
        bus.loop_en = lp;
        bus.stop = 1'b1;
        step("stop_to_idle", mk(0, 1'b0, 1'b0, 1'b0));
        bus.stop = 1'b0;
        bus.start = 1'b1;
        step("start", model(0, note, rest, lp));
        bus.start = 1'b0;
    endtask

    task automatic run_scen(input scen_t s);
        begin_tune(s.note, s.rest, s.loop_early);
        for (int k = 1; k < s.len; k++) begin
            bus.start = (k == s.poke);
            bus.loop_en = (k < 30) ? s.loop_early : s.loop_late;
            step(s.name, model(k, s.note, s.rest, s.loop_late));
        end
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.pause = 1'b0;
        bus.loop_en = 1'b0;
        tbl[0] = '{name:"plain",     note:10, rest:-1, loop_early:0, loop_late:0, poke:15, len:44};
        tbl[1] = '{name:"rest_addr1",note:10, rest:1,  loop_early:0, loop_late:0, poke:-1, len:44};
        tbl[2] = '{name:"odd_11",    note:11, rest:-1, loop_early:0, loop_late:0, poke:-1, len:42};
        tbl[3] = '{name:"fast_4",    note:4,  rest:-1, loop_early:0, loop_late:0, poke:-1, len:42};
        tbl[4] = '{name:"silent_1",  note:1,  rest:-1, loop_early:0, loop_late:0, poke:-1, len:42};
        tbl[5] = '{name:"loop",      note:6,  rest:-1, loop_early:1, loop_late:1, poke:-1, len:55};
        tbl[6] = '{name:"loop_off",  note:10, rest:-1, loop_early:1, loop_late:0, poke:-1, len:44};

        #1;
        check_now("reset_async", mk(0, 1'b0, 1'b0, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        check_now("reset_hold", mk(0, 1'b0, 1'b0, 1'b0));
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_scen(tbl[i]);

        // Pause mid-PLAY with beep high, then pause across FETCH/LATCH.
        begin_tune(10, -1, 1'b0);
        for (int k = 1; k <= 8; k++) step("pause_pre", model(k, 10, -1, 1'b0));
        bus.pause = 1'b1;
        repeat (20) step("pause_hold", mk(0, 1'b0, 1'b1, 1'b0));
        bus.pause = 1'b0;
        step("pause_release", mk(0, 1'b0, 1'b1, 1'b0));
        for (int k = 10; k <= 20; k++) step("pause_late_slot", model(k, 10, -1, 1'b0));
        bus.pause = 1'b1;
        repeat (5) step("pause_fetch", mk(2, 1'b0, 1'b1, 1'b0));
        bus.pause = 1'b0;
        for (int m = 23; m <= 42; m++) step("pause_tail", model(m, 10, -1, 1'b0));

        // Stop beats start in PLAY and in IDLE.
        begin_tune(10, -1, 1'b0);
        for (int k = 1; k <= 23; k++) step("stop_pre", model(k, 10, -1, 1'b0));
        bus.stop = 1'b1;
        bus.start = 1'b1;
        step("stop_beats_start", mk(0, 1'b0, 1'b0, 1'b0));
        bus.stop = 1'b0;
        bus.start = 1'b0;
        repeat (2) step("idle_hold", mk(0, 1'b0, 1'b0, 1'b0));
        bus.stop = 1'b1;
        bus.start = 1'b1;
        step("stop_start_idle", mk(0, 1'b0, 1'b0, 1'b0));
        bus.stop = 1'b0;
        bus.start = 1'b0;
        step("idle_after", mk(0, 1'b0, 1'b0, 1'b0));

        // Asynchronous reset in the middle of a note.
        begin_tune(10, -1, 1'b0);
        for (int k = 1; k <= 25; k++) step("rst_pre", model(k, 10, -1, 1'b0));
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_now("rst_async_mid", mk(0, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        check_now("rst_held", mk(0, 1'b0, 1'b0, 1'b0));
        rst_n = 1'b1;
        bus.start = 1'b1;
        step("rst_restart", model(0, 10, -1, 1'b0));
        bus.start = 1'b0;
        for (int k = 1; k <= 12; k++) step("rst_replay", model(k, 10, -1, 1'b0));

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
